// File: rtl/avalon_st_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : avalon_st_frame_capture
// Description : Single-clock Avalon-ST frame grabber. It captures one complete
//               packet, aligned to startofpacket, into on-chip RAM. An
//               Avalon-MM register window gives the host capture control,
//               status, the frame length and pixel readback with optional
//               auto-increment. A level interrupt reports done/overflow.
// Ports       : sink_clock, reset (sync, active-high)
//               sink_data/valid/startofpacket/endofpacket, sink_ready (=1)
//               mm_chipselect/address/read/readdata/write/writedata
//               irq
// Registers   : 0 DATA (R)      1 READ_PTR (R/W)   2 CTRL (R/W)
//               3 STATUS (R, W1C bits 1-2)          4 FRAME_LEN (R)
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_st_frame_capture #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 307200,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              sink_clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_startofpacket,
    input  logic              sink_endofpacket,
    input  logic              mm_chipselect,
    input  logic [2:0]        mm_address,
    input  logic              mm_read,
    output logic [31:0]       mm_readdata,
    input  logic              mm_write,
    input  logic [31:0]       mm_writedata,
    output logic              irq
);

    // The write pointer must be able to hold DEPTH itself (buffer full).
    localparam int                PTR_W     = ADDR_W + 1;
    localparam logic [PTR_W-1:0]  DEPTH_P   = PTR_W'(DEPTH);
    localparam logic [31:0]       DEPTH_32  = 32'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        CAPTURE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   frame_len;
    logic [PTR_W-1:0]   frame_len_next;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic               frame_end;
    logic               ovf_set;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic [ADDR_W-1:0]  read_ptr;
    logic               continuous;
    logic               auto_inc;
    logic               irq_en;
    logic               done;
    logic               overflow;
    logic [31:0]        rd_data;

    logic               mm_wr;
    logic               mm_rd;
    logic               ctrl_wr;
    logic               arm;
    logic               abort;

    assign sink_ready = 1'b1;

    assign mm_wr   = mm_chipselect & mm_write;
    assign mm_rd   = mm_chipselect & mm_read;
    assign ctrl_wr = mm_wr & (mm_address == 3'd2);
    // ABORT dominates ARM when both bits are written together.
    assign abort   = ctrl_wr & mm_writedata[4];
    assign arm     = ctrl_wr & mm_writedata[0] & ~mm_writedata[4];

    // ------------------------------------------------------------------
    // Capture FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sink_clock) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            frame_len <= '0;
        end else begin
            state     <= state_next;
            wr_ptr    <= wr_ptr_next;
            frame_len <= frame_len_next;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM: next state and RAM write control.
    // Host commands take precedence over a beat arriving in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state;
        wr_ptr_next    = wr_ptr;
        frame_len_next = frame_len;
        mem_we         = 1'b0;
        mem_waddr      = '0;
        frame_end      = 1'b0;
        ovf_set        = 1'b0;

        if (abort) begin
            state_next = IDLE;
        end else if (arm) begin
            state_next  = WAIT_SOP;
            wr_ptr_next = '0;
        end else if (sink_valid && (state != IDLE)) begin
            if (sink_startofpacket) begin
                // Frame start, or restart of an unfinished frame.
                mem_we      = 1'b1;
                mem_waddr   = '0;
                wr_ptr_next = PTR_W'(1);
                if (sink_endofpacket) begin
                    frame_end      = 1'b1;
                    frame_len_next = PTR_W'(1);
                end else begin
                    state_next = CAPTURE;
                end
            end else if (state == CAPTURE) begin
                if (wr_ptr < DEPTH_P) begin
                    mem_we      = 1'b1;
                    mem_waddr   = wr_ptr[ADDR_W-1:0];
                    wr_ptr_next = wr_ptr + PTR_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
                if (sink_endofpacket) begin
                    frame_end      = 1'b1;
                    frame_len_next = (wr_ptr < DEPTH_P) ? (wr_ptr + PTR_W'(1)) : DEPTH_P;
                end
            end
            if (frame_end) begin
                state_next = continuous ? WAIT_SOP : IDLE;
            end
        end
    end

    // Frame buffer: contents are intentionally not reset.
    always_ff @(posedge sink_clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= sink_data;
        end
    end

    // ------------------------------------------------------------------
    // Register read mux (zero-extended fields, unmapped reads 0)
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        case (mm_address)
            3'd0:    rd_data[DATA_W-1:0] = mem[read_ptr];
            3'd1:    rd_data[ADDR_W-1:0] = read_ptr;
            3'd2:    rd_data[3:1]        = {irq_en, auto_inc, continuous};
            3'd3:    rd_data[2:0]        = {overflow, done, (state != IDLE)};
            3'd4:    rd_data[PTR_W-1:0]  = frame_len;
            default: rd_data             = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Host-side registers. Later assignments in this block win, which
    // gives PTR write over auto-increment and flag set over W1C.
    // ------------------------------------------------------------------
    always_ff @(posedge sink_clock) begin
        if (reset) begin
            read_ptr    <= '0;
            continuous  <= 1'b0;
            auto_inc    <= 1'b0;
            irq_en      <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            mm_readdata <= '0;
            irq         <= 1'b0;
        end else begin
            irq <= irq_en & (done | overflow);

            if (mm_rd) begin
                mm_readdata <= rd_data;
            end

            if (mm_rd && (mm_address == 3'd0) && auto_inc) begin
                read_ptr <= (read_ptr == LAST_ADDR) ? '0 : (read_ptr + ADDR_W'(1));
            end
            if (mm_wr && (mm_address == 3'd1) && (mm_writedata < DEPTH_32)) begin
                read_ptr <= mm_writedata[ADDR_W-1:0];
            end

            if (ctrl_wr) begin
                continuous <= mm_writedata[1];
                auto_inc   <= mm_writedata[2];
                irq_en     <= mm_writedata[3];
            end

            if (mm_wr && (mm_address == 3'd3)) begin
                if (mm_writedata[1]) done     <= 1'b0;
                if (mm_writedata[2]) overflow <= 1'b0;
            end
            if (frame_end) done     <= 1'b1;
            if (ovf_set)   overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_st_frame_capture
// Description : Self-checking bench for avalon_st_frame_capture (DEPTH=8,
//               DATA_W=8). A frame-level reference model tracks the buffer,
//               flags and registers; every cycle irq, sink_ready and, after
//               each read, mm_readdata are compared against it. Directed
//               scenarios add literal expectations, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_st_frame_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] sink_data;
    logic              sink_valid;
    logic              sink_ready;
    logic              sink_startofpacket;
    logic              sink_endofpacket;
    logic              mm_chipselect;
    logic [2:0]        mm_address;
    logic              mm_read;
    logic [31:0]       mm_readdata;
    logic              mm_write;
    logic [31:0]       mm_writedata;
    logic              irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_st_frame_capture #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .sink_clock         (clk),
        .reset              (reset),
        .sink_data          (sink_data),
        .sink_valid         (sink_valid),
        .sink_ready         (sink_ready),
        .sink_startofpacket (sink_startofpacket),
        .sink_endofpacket   (sink_endofpacket),
        .mm_chipselect      (mm_chipselect),
        .mm_address         (mm_address),
        .mm_read            (mm_read),
        .mm_readdata        (mm_readdata),
        .mm_write           (mm_write),
        .mm_writedata       (mm_writedata),
        .irq                (irq)
    );

    // ------------------------------------------------------------------
    // Reference model: frame-level view of the grabber.
    // busy=0 idle; busy=1 with wcnt<0 waiting for SOP, else words seen.
    // ------------------------------------------------------------------
    logic [7:0]  m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy, m_cont, m_ainc, m_ien, m_done, m_ovf, m_irq;
    int          m_wcnt, m_flen, m_rptr;
    logic [31:0] m_exp_rd;
    bit          m_rd_valid;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        bit          rd, wr, inext, m_abort, m_arm;
        int          a, total;
        logic [31:0] wd;
        if (reset) begin
            m_busy = 0; m_cont = 0; m_ainc = 0; m_ien = 0; m_done = 0; m_ovf = 0;
            m_irq = 0; m_wcnt = -1; m_flen = 0; m_rptr = 0;
            m_exp_rd = 0; m_rd_valid = 1; cmp_en = 1;
        end else begin
            rd = mm_chipselect && mm_read;
            wr = mm_chipselect && mm_write;
            a  = int'(mm_address);
            wd = mm_writedata;
            m_rd_valid = 0;
            if (rd) begin
                m_rd_valid = 1;
                case (a)
                    0: begin m_exp_rd = 32'(m_mem[m_rptr]); m_rd_valid = m_known[m_rptr]; end
                    1: m_exp_rd = 32'(m_rptr);
                    2: m_exp_rd = 32'(2 * m_cont + 4 * m_ainc + 8 * m_ien);
                    3: m_exp_rd = 32'(m_busy + 2 * m_done + 4 * m_ovf);
                    4: m_exp_rd = 32'(m_flen);
                    default: m_exp_rd = 0;
                endcase
            end
            inext = m_ien && (m_done || m_ovf);
            if (rd && a == 0 && m_ainc) m_rptr = (m_rptr + 1) % DEPTH;
            if (wr && a == 1 && wd < DEPTH) m_rptr = int'(wd);
            if (wr && a == 3) begin
                if (wd[1]) m_done = 0;
                if (wd[2]) m_ovf = 0;
            end
            m_abort = wr && a == 2 && wd[4];
            m_arm   = wr && a == 2 && wd[0] && !wd[4];
            if (m_abort) begin
                m_busy = 0;
            end else if (m_arm) begin
                m_busy = 1; m_wcnt = -1;
            end else if (m_busy && sink_valid) begin
                total = -1;
                if (sink_startofpacket) begin
                    m_mem[0] = sink_data; m_known[0] = 1; m_wcnt = 1;
                    if (sink_endofpacket) total = 1;
                end else if (m_wcnt >= 0) begin
                    if (m_wcnt < DEPTH) begin
                        m_mem[m_wcnt] = sink_data; m_known[m_wcnt] = 1;
                    end else begin
                        m_ovf = 1;
                    end
                    if (sink_endofpacket) total = m_wcnt + 1;
                    if (m_wcnt < DEPTH) m_wcnt++;
                end
                if (total > 0) begin
                    m_flen = (total < DEPTH) ? total : DEPTH;
                    m_done = 1;
                    if (m_cont) m_wcnt = -1;
                    else        m_busy = 0;
                end
            end
            if (wr && a == 2) begin
                m_cont = wd[1]; m_ainc = wd[2]; m_ien = wd[3];
            end
            m_irq = inext;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (irq !== m_irq) begin
                errors++;
                $display("FAIL irq t=%0t got %b want %b", $time, irq, m_irq);
            end
            checks++;
            if (sink_ready !== 1'b1) begin
                errors++;
                $display("FAIL sink_ready t=%0t got %b want 1", $time, sink_ready);
            end
            if (m_rd_valid) begin
                checks++;
                if (mm_readdata !== m_exp_rd) begin
                    errors++;
                    $display("FAIL readdata t=%0t got %h want %h", $time, mm_readdata, m_exp_rd);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change just after the falling edge)
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        sink_data = '0; sink_valid = 0; sink_startofpacket = 0; sink_endofpacket = 0;
        mm_chipselect = 0; mm_address = '0; mm_read = 0; mm_write = 0; mm_writedata = '0;
    endtask

    task automatic mm_wr(input logic [2:0] a, input logic [31:0] d);
        mm_chipselect = 1; mm_write = 1; mm_address = a; mm_writedata = d;
        @(negedge clk);
        mm_chipselect = 0; mm_write = 0;
    endtask

    task automatic mm_rd(input logic [2:0] a, output logic [31:0] d);
        mm_chipselect = 1; mm_read = 1; mm_address = a;
        @(negedge clk);
        mm_chipselect = 0; mm_read = 0;
        d = mm_readdata;
    endtask

    task automatic beat(input logic [7:0] d, input logic sop, input logic eop);
        sink_valid = 1; sink_data = d; sink_startofpacket = sop; sink_endofpacket = eop;
        @(negedge clk);
        sink_valid = 0; sink_startofpacket = 0; sink_endofpacket = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    logic [31:0] rd;

    initial begin
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        // Reset state
        chk("rst_readdata", mm_readdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        mm_rd(3'd3, rd); chk("rst_status", rd, 32'h0);
        mm_rd(3'd4, rd); chk("rst_frame_len", rd, 32'h0);
        mm_rd(3'd2, rd); chk("rst_ctrl", rd, 32'h0);
        mm_rd(3'd1, rd); chk("rst_read_ptr", rd, 32'h0);

        // Arm, unaligned beats dropped, then a 5-beat frame
        mm_wr(3'd2, 32'h1);
        for (int i = 0; i < 3; i++) beat(8'hE0 + 8'(i), 0, 0);
        for (int i = 0; i < 5; i++) beat(8'h10 + 8'(i), i == 0, i == 4);
        mm_rd(3'd4, rd); chk("f1_frame_len", rd, 32'd5);
        mm_rd(3'd3, rd); chk("f1_status", rd, 32'h2);
        mm_wr(3'd1, 32'h0);
        mm_wr(3'd2, 32'h4);
        for (int i = 0; i < 5; i++) begin
            mm_rd(3'd0, rd); chk("f1_data", rd, 32'h10 + 32'(i));
        end
        mm_rd(3'd1, rd); chk("f1_read_ptr", rd, 32'd5);

        // Overflow: 12-beat frame into 8 words
        mm_wr(3'd3, 32'h2);
        mm_wr(3'd2, 32'h1);
        for (int i = 0; i < 12; i++) beat(8'h20 + 8'(i), i == 0, i == 11);
        mm_rd(3'd4, rd); chk("ovf_frame_len", rd, 32'd8);
        mm_rd(3'd3, rd); chk("ovf_status", rd, 32'h6);
        chk("ovf_irq_disabled", {31'b0, irq}, 32'h0);
        mm_wr(3'd2, 32'h8);
        chk("irq_lag_low", {31'b0, irq}, 32'h0);
        @(negedge clk);
        chk("irq_high", {31'b0, irq}, 32'h1);
        mm_wr(3'd3, 32'h6);
        chk("irq_w1c_lag", {31'b0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_w1c_low", {31'b0, irq}, 32'h0);
        mm_wr(3'd1, 32'd7);
        mm_wr(3'd2, 32'hC);
        mm_rd(3'd0, rd); chk("ovf_last_word", rd, 32'h27);
        mm_rd(3'd1, rd); chk("autoinc_wrap", rd, 32'h0);

        // Continuous mode: three back-to-back frames
        mm_wr(3'd2, 32'h3);
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 4; i++) beat(8'(4 * f + i + 1), i == 0, i == 3);
        mm_rd(3'd3, rd); chk("cont_status", rd, 32'h3);
        mm_rd(3'd4, rd); chk("cont_frame_len", rd, 32'd4);
        mm_wr(3'd1, 32'h0);
        mm_wr(3'd2, 32'h6);
        for (int i = 0; i < 4; i++) begin
            mm_rd(3'd0, rd); chk("cont_data", rd, 32'd9 + 32'(i));
        end

        // Abort while waiting, then mid-frame restart
        mm_wr(3'd2, 32'h10);
        mm_rd(3'd3, rd); chk("abort_idle_status", rd, 32'h2);
        mm_wr(3'd3, 32'h6);
        mm_wr(3'd2, 32'h1);
        beat(8'h30, 1, 0); beat(8'h31, 0, 0); beat(8'h32, 0, 0);
        beat(8'h40, 1, 0); beat(8'h41, 0, 0); beat(8'h42, 0, 1);
        mm_rd(3'd4, rd); chk("restart_frame_len", rd, 32'd3);
        mm_wr(3'd1, 32'h0);
        mm_wr(3'd2, 32'h4);
        mm_rd(3'd0, rd); chk("restart_buf0", rd, 32'h40);

        // Single-beat frame, abort in capture, out-of-range PTR write
        mm_wr(3'd3, 32'h2);
        mm_wr(3'd2, 32'h1);
        beat(8'h55, 1, 1);
        mm_rd(3'd4, rd); chk("single_frame_len", rd, 32'd1);
        mm_rd(3'd3, rd); chk("single_status", rd, 32'h2);
        mm_wr(3'd2, 32'h1);
        beat(8'h60, 1, 0); beat(8'h61, 0, 0);
        mm_rd(3'd3, rd); chk("capture_busy", rd, 32'h3);
        mm_wr(3'd2, 32'h11);
        mm_rd(3'd3, rd); chk("abort_status", rd, 32'h2);
        mm_rd(3'd4, rd); chk("abort_frame_len", rd, 32'd1);
        mm_wr(3'd1, 32'd3);
        mm_wr(3'd1, 32'd8);
        mm_rd(3'd1, rd); chk("ptr_oob_ignored", rd, 32'd3);

        // Reset mid-frame, later beats ignored until ARM
        mm_wr(3'd2, 32'h9);
        beat(8'h70, 1, 0); beat(8'h71, 0, 0);
        pulse_reset();
        beat(8'h80, 1, 0); beat(8'h81, 0, 0); beat(8'h82, 0, 1);
        mm_rd(3'd3, rd); chk("rst_mid_status", rd, 32'h0);
        mm_rd(3'd4, rd); chk("rst_mid_frame_len", rd, 32'h0);
        mm_rd(3'd2, rd); chk("rst_mid_ctrl", rd, 32'h0);
        chk("rst_mid_irq", {31'b0, irq}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset              = ($urandom_range(0, 499) == 0);
            sink_valid         = ($urandom_range(0, 1) == 1);
            sink_data          = 8'($urandom_range(0, 255));
            sink_startofpacket = ($urandom_range(0, 6) == 0);
            sink_endofpacket   = ($urandom_range(0, 4) == 0);
            mm_chipselect      = ($urandom_range(0, 3) != 0);
            mm_address         = 3'($urandom_range(0, 5));
            mm_read            = ($urandom_range(0, 2) == 0);
            mm_write           = ($urandom_range(0, 9) == 0);
            case (mm_address)
                3'd1:    mm_writedata = 32'($urandom_range(0, 9));
                3'd2:    mm_writedata = 32'($urandom_range(0, 15)) |
                                        (($urandom_range(0, 7) == 0) ? 32'h10 : 32'h0);
                3'd3:    mm_writedata = 32'($urandom_range(0, 7));
                default: mm_writedata = $urandom;
            endcase
            @(negedge clk);
        end
        idle_inputs();
        reset = 0;
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
